// File: rtl/vesp_boot_loader.sv
// Boot sequencer for the VeSP core: zero-fills the low memory region, then
// streams a program image into memory while holding the CPU in reset.
module vesp_boot_loader #(
    parameter int WORD_SIZE   = 16,
    parameter int ADDR_SIZE   = 12,
    parameter int CLEAR_DEPTH = 256,
    parameter int LOAD_BASE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 prog_valid,
    input  logic [WORD_SIZE-1:0] prog_data,
    input  logic                 prog_last,
    output logic                 prog_ready,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_SIZE:0]   load_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_SIZE-1:0] CLR_LAST = ADDR_SIZE'(CLEAR_DEPTH - 1);
    localparam logic [ADDR_SIZE-1:0] LD_FIRST = ADDR_SIZE'(LOAD_BASE);
    localparam logic [ADDR_SIZE-1:0] ADDR_MAX = '1;

    state_t               state_reg;
    logic [ADDR_SIZE-1:0] clr_addr_reg;
    logic [ADDR_SIZE-1:0] ld_addr_reg;
    logic [ADDR_SIZE:0]   load_count_reg;
    logic                 prog_ready_reg;
    logic                 mem_we_reg;
    logic [ADDR_SIZE-1:0] mem_addr_reg;
    logic [WORD_SIZE-1:0] mem_wdata_reg;
    logic                 cpu_hold_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 error_reg;
    logic                 beat;

    // prog_ready_reg is only ever high while in LOAD, so this is a LOAD beat
    assign beat = prog_valid && prog_ready_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            clr_addr_reg   <= '0;
            ld_addr_reg    <= '0;
            load_count_reg <= '0;
            prog_ready_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_hold_reg   <= 1'b1;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_reg      <= S_CLEAR;
                        clr_addr_reg   <= '0;
                        load_count_reg <= '0;
                        cpu_hold_reg   <= 1'b1;
                        busy_reg       <= 1'b1;
                        done_reg       <= 1'b0;
                        error_reg      <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    mem_we_reg    <= 1'b1;
                    mem_addr_reg  <= clr_addr_reg;
                    mem_wdata_reg <= '0;
                    clr_addr_reg  <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == CLR_LAST) begin
                        state_reg      <= S_LOAD;
                        ld_addr_reg    <= LD_FIRST;
                        prog_ready_reg <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        mem_we_reg     <= 1'b1;
                        mem_addr_reg   <= ld_addr_reg;
                        mem_wdata_reg  <= prog_data;
                        load_count_reg <= load_count_reg + 1'b1;
                        if (prog_last) begin
                            state_reg      <= S_DONE;
                            prog_ready_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            done_reg       <= 1'b1;
                            cpu_hold_reg   <= 1'b0;
                        end else if (ld_addr_reg == ADDR_MAX) begin
                            // top of memory reached without prog_last: stop, never wrap
                            state_reg      <= S_ERROR;
                            prog_ready_reg <= 1'b0;
                            busy_reg       <= 1'b0;
                            error_reg      <= 1'b1;
                        end else begin
                            ld_addr_reg <= ld_addr_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign prog_ready = prog_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign cpu_hold   = cpu_hold_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign load_count = load_count_reg;

endmodule

// File: tb/tb_vesp_boot_loader.sv
// Randomized self-checking bench: expected write streams and status values
// are rebuilt from the clear/load rules and compared with observed writes.
module tb_vesp_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, prog_valid, prog_last;
    logic [15:0] prog_data;
    logic        prog_ready, mem_we, cpu_hold, busy, done, error;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [12:0] load_count;

    logic        start_s, pv_s, pl_s;
    logic [15:0] pd_s;
    logic        pr_s, we_s, hold_s, busy_s, done_s, err_s;
    logic [3:0]  addr_s;
    logic [15:0] wd_s;
    logic [4:0]  lc_s;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int wa_q[$], wd_q[$], wc_q[$];
    int sa_q[$], sd_q[$];
    int img_q[$];

    always #5 clk = ~clk;

    vesp_boot_loader #(.WORD_SIZE(16), .ADDR_SIZE(12), .CLEAR_DEPTH(256), .LOAD_BASE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .load_count(load_count)
    );

    vesp_boot_loader #(.WORD_SIZE(16), .ADDR_SIZE(4), .CLEAR_DEPTH(16), .LOAD_BASE(14)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .prog_valid(pv_s),
        .prog_data(pd_s), .prog_last(pl_s), .prog_ready(pr_s),
        .mem_we(we_s), .mem_addr(addr_s), .mem_wdata(wd_s),
        .cpu_hold(hold_s), .busy(busy_s), .done(done_s), .error(err_s),
        .load_count(lc_s)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(int'(mem_addr));
            wd_q.push_back(int'(mem_wdata));
            wc_q.push_back(cyc);
        end
        if (we_s) begin
            sa_q.push_back(int'(addr_s));
            sd_q.push_back(int'(wd_s));
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int k;
        k = 0;
        while (!prog_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready_seen"}, prog_ready, 1'b1);
    endtask

    // Drives img_q; each word is preceded by gap_lo..gap_hi idle cycles.
    task automatic load_image(input int gap_lo, input int gap_hi, input bit poke_start);
        int g;
        for (int i = 0; i < img_q.size(); i++) begin
            g = int'($urandom_range(gap_hi, gap_lo));
            repeat (g) begin
                prog_valid = 1'b0;
                prog_data  = 16'($urandom);
                prog_last  = 1'($urandom);
                start      = poke_start;
                @(negedge clk);
            end
            start      = 1'b0;
            prog_valid = 1'b1;
            prog_data  = 16'(img_q[i]);
            prog_last  = (i == img_q.size() - 1);
            $display("[TB] beat %0d data %04h last %0d", i, prog_data, prog_last);
            @(negedge clk);
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int gap_lo, input int gap_hi, input bit poke_start);
        int n_exp, ea, ed;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_start"}, busy, 1'b1);
        check({tag, "_hold_start"}, cpu_hold, 1'b1);
        check({tag, "_done_start"}, done, 1'b0);
        check({tag, "_cnt_start"}, load_count, 0);
        wait_ready(tag, 300);
        load_image(gap_lo, gap_hi, poke_start);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_hold_rel"}, cpu_hold, 1'b0);
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_ready_drop"}, prog_ready, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_load_count"}, load_count, img_q.size());
        repeat (3) @(negedge clk);
        n_exp = 256 + img_q.size();
        check({tag, "_nwrites"}, wa_q.size(), n_exp);
        for (int i = 0; i < n_exp && i < wa_q.size(); i++) begin
            ea = (i < 256) ? i : i - 256;
            ed = (i < 256) ? 0 : img_q[i - 256];
            check({tag, "_waddr"}, wa_q[i], ea);
            check({tag, "_wdata"}, wd_q[i], ed);
        end
        if (wc_q.size() >= 256) check({tag, "_clr_span"}, wc_q[255] - wc_q[0], 255);
        $display("[TB] run %s: %0d words loaded", tag, img_q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        int n0;
        rst = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
        start_s = 1'b0; pv_s = 1'b0; pl_s = 1'b0; pd_s = '0;
        repeat (3) @(negedge clk);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ready", prog_ready, 1'b0);
        check("rst_hold", cpu_hold, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_count", load_count, 0);
        rst = 1'b0;
        @(negedge clk);

        img_q = '{16'h2000, 16'h1458, 16'h8000, 16'hD000, 16'h7000};
        run_and_check("spec", 0, 0, 1'b0);
        run_and_check("gap3", 3, 3, 1'b1);

        // Reset while clearing: wait until the write of address 99 is visible
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            if (mem_we && mem_addr == 12'd99) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reach", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_we", mem_we, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_hold", cpu_hold, 1'b1);
        check("abort_ready", prog_ready, 1'b0);
        n0 = wa_q.size();
        check("abort_nwrites", n0, 100);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_quiet", wa_q.size(), n0);
        check("abort_idle_busy", busy, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(10, 1));
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back(int'($urandom_range(16'hFFFF, 0)));
            run_and_check($sformatf("rand%0d", r), 0, 2, 1'($urandom));
        end

        // Overflow at the top of a 16-word address space
        sa_q.delete(); sd_q.delete();
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int k = 0; k < 40 && !pr_s; k++) @(negedge clk);
        check("ovf_ready_seen", pr_s, 1'b1);
        pv_s = 1'b1; pl_s = 1'b0; pd_s = 16'hAAAA;
        @(negedge clk);
        pd_s = 16'hBBBB;
        @(negedge clk);
        check("ovf_error", err_s, 1'b1);
        check("ovf_hold", hold_s, 1'b1);
        check("ovf_ready", pr_s, 1'b0);
        check("ovf_busy", busy_s, 1'b0);
        check("ovf_done", done_s, 1'b0);
        check("ovf_count", lc_s, 2);
        pd_s = 16'hCCCC;
        repeat (3) @(negedge clk);
        pv_s = 1'b0;
        check("ovf_nwrites", sa_q.size(), 18);
        for (int i = 0; i < 18 && i < sa_q.size(); i++) begin
            check("ovf_waddr", sa_q[i], (i < 16) ? i : 14 + (i - 16));
            check("ovf_wdata", sd_q[i], (i < 16) ? 0 : ((i == 16) ? 16'hAAAA : 16'hBBBB));
        end
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("ovf_restart_err", err_s, 1'b0);
        check("ovf_restart_busy", busy_s, 1'b1);
        check("ovf_restart_hold", hold_s, 1'b1);
        check("ovf_restart_cnt", lc_s, 0);
        $display("[TB] overflow run complete");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
